// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter: one digit per cycle, MSD first,
// acc = acc*10 + digit via shift-add, saturating at 2^OUT_WIDTH-1.

module bcd_nibble_chk (
  input  logic [3:0] nib_i,
  output logic       bad_o
);
  assign bad_o = (nib_i > 4'd9);
endmodule

module bcd_to_binary_converter #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_WIDTH  = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_WIDTH-1:0]    result,
  output logic                    overflow,
  output logic                    invalidDigit
);

  localparam int AW = OUT_WIDTH + 4;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_DIGITS - 1);
  localparam logic [AW-1:0] MAX_EXT  = {4'b0, {OUT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [OUT_WIDTH-1:0]    acc_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q, done_q, ovf_q, inv_q;
  logic [OUT_WIDTH-1:0]    result_q;

  // Per-digit validity, evaluated on the live input at acceptance.
  logic [NUM_DIGITS-1:0] bad;
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_chk
      bcd_nibble_chk u_chk (.nib_i(digits[4*g +: 4]), .bad_o(bad[g]));
    end
  endgenerate

  // Latched digits shift left each step, so the MSD slot is always current.
  logic [3:0]           cur_dig;
  logic [AW-1:0]        acc_ext, sum_d;
  logic                 sat_d;
  logic [OUT_WIDTH-1:0] acc_d;

  always_comb begin
    cur_dig = dig_q[4*NUM_DIGITS-1 -: 4];
    acc_ext = {4'b0, acc_q};
    sum_d   = (acc_ext << 3) + (acc_ext << 1) + {{OUT_WIDTH{1'b0}}, cur_dig};
    sat_d   = (sum_d > MAX_EXT);
    acc_d   = sat_d ? {OUT_WIDTH{1'b1}} : sum_d[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dig_q    <= digits;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= |bad;
            busy_q   <= 1'b1;
            if (|bad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          dig_q <= dig_q << 4;
          cnt_q <= cnt_q + 1'b1;
          // Sequence is monotone, so once clamped the flag stays meaningful.
          if (sat_d) ovf_q <= 1'b1;
          if (cnt_q == LAST_CNT) begin
            result_q <= acc_d;
            state_q  <= DONE;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign overflow     = ovf_q;
  assign invalidDigit = inv_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Randomized bench for bcd_to_binary_converter across three parameter sets,
// checked against a decimal-value reference model.

module tb_bcd_to_binary_converter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // u0: 4 digits / 13 bits, u1: 2 / 7, u2: 3 / 9
  logic        st0 = 0, st1 = 0, st2 = 0;
  logic [15:0] dig0 = '0;
  logic [7:0]  dig1 = '0;
  logic [11:0] dig2 = '0;
  logic        bsy0, bsy1, bsy2, dn0, dn1, dn2;
  logic        ov0, ov1, ov2, iv0, iv1, iv2;
  logic [12:0] res0;
  logic [6:0]  res1;
  logic [8:0]  res2;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_binary_converter #(.NUM_DIGITS(4), .OUT_WIDTH(13)) u0 (
    .clk(clk), .reset(reset), .start(st0), .digits(dig0), .busy(bsy0), .done(dn0),
    .result(res0), .overflow(ov0), .invalidDigit(iv0));
  bcd_to_binary_converter #(.NUM_DIGITS(2), .OUT_WIDTH(7)) u1 (
    .clk(clk), .reset(reset), .start(st1), .digits(dig1), .busy(bsy1), .done(dn1),
    .result(res1), .overflow(ov1), .invalidDigit(iv1));
  bcd_to_binary_converter #(.NUM_DIGITS(3), .OUT_WIDTH(9)) u2 (
    .clk(clk), .reset(reset), .start(st2), .digits(dig2), .busy(bsy2), .done(dn2),
    .result(res2), .overflow(ov2), .invalidDigit(iv2));

  // Reference: full decimal value, then saturate; any bad nibble wins.
  function automatic void ref_conv(input logic [15:0] d, input int nd, input int ow,
                                   output logic [12:0] r, output logic ov, output logic iv);
    longint v = 0;
    longint mx = (longint'(1) << ow) - 1;
    logic [3:0] nib;
    iv = 1'b0;
    for (int k = nd - 1; k >= 0; k--) begin
      nib = d[4*k +: 4];
      if (nib > 4'd9) iv = 1'b1;
      v = v * 10 + longint'(nib);
    end
    if (iv) begin r = '0; ov = 1'b0; end
    else if (v > mx) begin r = 13'(mx); ov = 1'b1; end
    else begin r = 13'(v); ov = 1'b0; end
  endfunction

  function automatic logic [15:0] rand_digits(input int nd);
    logic [15:0] d = '0;
    for (int k = 0; k < nd; k++)
      d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic set_in(input int u, input logic s, input logic [15:0] d);
    case (u)
      0: begin st0 = s; dig0 = d; end
      1: begin st1 = s; dig1 = d[7:0]; end
      default: begin st2 = s; dig2 = d[11:0]; end
    endcase
  endtask

  task automatic sample(input int u, output logic b, output logic dn, output logic [12:0] r,
                        output logic ov, output logic iv);
    case (u)
      0: begin b = bsy0; dn = dn0; r = res0; ov = ov0; iv = iv0; end
      1: begin b = bsy1; dn = dn1; r = {6'b0, res1}; ov = ov1; iv = iv1; end
      default: begin b = bsy2; dn = dn2; r = {4'b0, res2}; ov = ov2; iv = iv2; end
    endcase
  endtask

  // Driver/monitor: one start pulse, then a fixed observation window.
  // lat = cycles from the start cycle to the first done cycle (0 if none).
  task automatic run_conv(input int u, input logic [15:0] d, output int lat, output int dcnt,
                          output int bcnt, output logic [12:0] r, output logic ov, output logic iv);
    logic b, dn, o, i;
    logic [12:0] rr;
    lat = 0; dcnt = 0; bcnt = 0; r = '1; ov = 1'bx; iv = 1'bx;
    @(negedge clk); set_in(u, 1'b1, d);
    @(negedge clk); set_in(u, 1'b0, 16'h0);
    for (int j = 0; j < 14; j++) begin
      sample(u, b, dn, rr, o, i);
      if (b) bcnt++;
      if (dn) begin
        dcnt++;
        if (lat == 0) begin lat = j + 1; r = rr; ov = o; iv = i; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({bsy0, dn0, ov0, iv0} !== 4'b0) begin n_errors++; $display("FAIL reset_flags0 got=%b exp=0000", {bsy0, dn0, ov0, iv0}); end
    n_checks++; if (res0 !== 13'd0) begin n_errors++; $display("FAIL reset_result0 got=%0d exp=0", res0); end
    n_checks++; if ({bsy1, dn1, ov1, iv1, res1} !== 11'b0) begin n_errors++; $display("FAIL reset_u1 got=%b exp=0", {bsy1, dn1, ov1, iv1, res1}); end
    n_checks++; if ({bsy2, dn2, ov2, iv2, res2} !== 13'b0) begin n_errors++; $display("FAIL reset_u2 got=%b exp=0", {bsy2, dn2, ov2, iv2, res2}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_conv(input string nm, input int u, input int nd, input int ow, input logic [15:0] d);
    int lat, dcnt, bcnt, exp_lat;
    logic [12:0] r, er;
    logic ov, iv, eov, eiv;
    ref_conv(d, nd, ow, er, eov, eiv);
    exp_lat = eiv ? 1 : nd + 1;
    run_conv(u, d, lat, dcnt, bcnt, r, ov, iv);
    n_checks++; if (r !== er) begin n_errors++; $display("FAIL %s_result d=%h got=%0d exp=%0d", nm, d, r, er); end
    n_checks++; if ({ov, iv} !== {eov, eiv}) begin n_errors++; $display("FAIL %s_flags d=%h got ov/iv=%b%b exp=%b%b", nm, d, ov, iv, eov, eiv); end
    n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL %s_latency d=%h got=%0d exp=%0d", nm, d, lat, exp_lat); end
    n_checks++; if (dcnt !== 1) begin n_errors++; $display("FAIL %s_done_count d=%h got=%0d exp=1", nm, d, dcnt); end
    n_checks++; if (bcnt !== exp_lat) begin n_errors++; $display("FAIL %s_busy_cycles d=%h got=%0d exp=%0d", nm, d, bcnt, exp_lat); end
  endtask

  task automatic test_basic();
    check_conv("basic", 0, 4, 13, 16'h1234);
  endtask

  task automatic test_boundary();
    check_conv("bnd8191", 0, 4, 13, 16'h8191);
    check_conv("bnd8192", 0, 4, 13, 16'h8192);
    check_conv("bnd9999", 0, 4, 13, 16'h9999);
  endtask

  task automatic test_invalid_zero();
    check_conv("invalid", 0, 4, 13, 16'h12A4);
    check_conv("zero", 0, 4, 13, 16'h0000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) check_conv("rand", 0, 4, 13, rand_digits(4));
  endtask

  task automatic test_start_while_busy();
    int dcnt = 0, first = -1, second = -1;
    logic [12:0] r1 = '1, r2 = '1;
    @(negedge clk); set_in(0, 1'b1, 16'h0042);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 0) set_in(0, 1'b0, 16'h0042);
      if (j == 1) set_in(0, 1'b1, 16'h9000);
      if (j == 2) set_in(0, 1'b0, 16'h7777);
      if (dn0) begin dcnt++; r1 = res0; end
    end
    n_checks++; if (r1 !== 13'd42) begin n_errors++; $display("FAIL busy_ignore_result got=%0d exp=42", r1); end
    n_checks++; if (dcnt !== 1) begin n_errors++; $display("FAIL busy_ignore_done_count got=%0d exp=1", dcnt); end
    // Held start: re-accepted on first IDLE edge with the digits present then.
    dcnt = 0;
    @(negedge clk); set_in(0, 1'b1, 16'h0042);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (dn0) begin
        dcnt++;
        if (first < 0) begin first = j; r1 = res0; set_in(0, 1'b1, 16'h0123); end
        else if (second < 0) begin second = j; r2 = res0; set_in(0, 1'b0, 16'h0); end
      end
    end
    set_in(0, 1'b0, 16'h0);
    n_checks++; if (r1 !== 13'd42) begin n_errors++; $display("FAIL held_first_result got=%0d exp=42", r1); end
    n_checks++; if (r2 !== 13'd123) begin n_errors++; $display("FAIL held_second_result got=%0d exp=123", r2); end
    n_checks++; if (second - first !== 6) begin n_errors++; $display("FAIL held_gap got=%0d exp=6", second - first); end
    n_checks++; if (dcnt !== 2) begin n_errors++; $display("FAIL held_done_count got=%0d exp=2", dcnt); end
  endtask

  task automatic test_reset_mid();
    int lat, dcnt, bcnt;
    logic [12:0] r;
    logic ov, iv;
    @(negedge clk); set_in(0, 1'b1, 16'h5555);
    @(negedge clk); set_in(0, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({bsy0, dn0} !== 2'b00) begin n_errors++; $display("FAIL midrst_busy_done got=%b exp=00", {bsy0, dn0}); end
    n_checks++; if (res0 !== 13'd0) begin n_errors++; $display("FAIL midrst_result got=%0d exp=0", res0); end
    reset = 1'b0;
    dcnt = 0;
    repeat (10) begin @(negedge clk); if (dn0) dcnt++; end
    n_checks++; if (dcnt !== 0) begin n_errors++; $display("FAIL midrst_spurious_done got=%0d exp=0", dcnt); end
    run_conv(0, 16'h0007, lat, dcnt, bcnt, r, ov, iv);
    n_checks++; if (r !== 13'd7) begin n_errors++; $display("FAIL midrst_after_result got=%0d exp=7", r); end
  endtask

  task automatic test_param_sweep();
    check_conv("p2_99", 1, 2, 7, 16'h0099);
    check_conv("p3_600", 2, 3, 9, 16'h0600);
    for (int n = 0; n < 10; n++) check_conv("p2_rand", 1, 2, 7, rand_digits(2));
    for (int n = 0; n < 10; n++) check_conv("p3_rand", 2, 3, 9, rand_digits(3));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_invalid_zero();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_converter.md
Name: bcd_to_binary_converter

Overview:
- Sequential decimal-to-binary converter; the inverse of the design's binary divide-by-ten digit path.
- Takes NUM_DIGITS packed BCD digits, for example keypad or stored high-score entry.
- Accumulates one digit per cycle, most significant digit first, as acc = acc*10 + digit.
- Produces an OUT_WIDTH-bit binary value for the reaction-time comparison and score logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits accepted per conversion (supported range 1..4).
- OUT_WIDTH, 13, width of the binary result; maximum representable value is 2^OUT_WIDTH-1 (8191).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when busy=0.
- digits  input  4*NUM_DIGITS  packed BCD; [4*NUM_DIGITS-1 -: 4] is the most significant digit.
- busy  output  1  high from the cycle after an accepted start until the return to IDLE.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  OUT_WIDTH  binary value; held until the next accepted start.
- overflow  output  1  the decimal value exceeded 2^OUT_WIDTH-1; result is saturated.
- invalidDigit  output  1  a nibble greater than 9 was present at acceptance.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - busy, done, result, overflow and invalidDigit all go to 0.
  - Internal accumulator, digit counter and latched digits are cleared.
  - Reset has priority over every other event, including mid-conversion. An aborted conversion produces no done pulse.
- States are IDLE, ACCUM and DONE. busy = (state != IDLE).
- IDLE, on start=1 at an edge:
  - Latch digits; clear the accumulator and the counter.
  - Clear result, overflow and invalidDigit.
  - If any latched nibble is greater than 9: go to DONE with invalidDigit=1, result=0, overflow=0 (latency 1 edge).
  - Otherwise go to ACCUM.
- ACCUM: each edge processes the digit selected by the counter (counter 0 selects the MSD).
  - next = (acc<<3) + (acc<<1) + digit, computed at OUT_WIDTH+4 bits. Shift-add only; no multiplier.
  - If next > 2^OUT_WIDTH-1: set sticky overflow and clamp acc to 2^OUT_WIDTH-1.
  - Clamping is valid because the sequence is monotone non-decreasing.
  - After the NUM_DIGITS-th accumulation edge: result <= final acc, state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1. The next edge goes to IDLE with done=0.
- Latency for a valid conversion:
  - start sampled at edge 0; accumulation on edges 1..NUM_DIGITS.
  - done high in the cycle after edge NUM_DIGITS (cycle 5 for the default).
  - IDLE again after edge NUM_DIGITS+1.
  - Back-to-back: a start held high is re-accepted on the first edge in IDLE.
- start while busy=1 is ignored. The digits input may change freely after acceptance without affecting the conversion.
- Leading zero digits contribute 0. The all-zero input yields result=0 with no flags.
- result, overflow and invalidDigit hold their values after done until the next accepted start or reset.

Test Plan:
- Basic conversion: reset, then start with digits=16'h1234 → done pulses exactly one cycle, 5 cycles after start; result=1234 (13'h04D2); overflow=0, invalidDigit=0; busy high for 5 cycles.
- Boundary: digits=16'h8191 → result=8191, overflow=0. Then digits=16'h8192 → result=8191, overflow=1. Then 16'h9999 → result=8191, overflow=1.
- Invalid and zero digits: digits=16'h12A4 → done 1 cycle after start (one edge later), invalidDigit=1, result=0, overflow=0. Then 16'h0000 → result=0, no flags.
- Start while busy: start with 16'h0042; pulse start with 16'h9000 on cycle 2 and change digits → result=42, a single done pulse. A start held through DONE is accepted on the first IDLE edge and converts the current digits.
- Reset mid-operation: start with 16'h5555; assert reset on cycle 3 → next cycle busy=0, result=0, no done pulse. A new start with 16'h0007 → result=7.
- Parameter sweep: NUM_DIGITS=2, OUT_WIDTH=7, digits=8'h99 → result=99, done 3 cycles after start. Then NUM_DIGITS=3, OUT_WIDTH=9, digits=12'h600 → result=511, overflow=1.
